// File: rtl/aes_host_ctrl.sv
// aes_host_ctrl: host-side sequencer for an AES core with an init/next command interface.
//
// A key-load request (cfg_*) issues core_init. A block accepted on the in_* valid/ready
// handshake issues core_next. Operands are latched on the accepting edge and held stable
// until the next accepted command. Each core result is captured into a valid/ready output
// register (out_*).
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cfg_load/cfg_ready        key-load request handshake (cfg_key, cfg_keylen)
//   key_valid                 an expanded key is present in the core
//   in_valid/in_ready         block input handshake (in_block, in_encdec)
//   out_valid/out_ready       result output handshake (out_block)
//   err_timeout               sticky watchdog flag
//   core_init/core_next       single-cycle command pulses to the core
//   core_key/keylen/block/encdec  latched operands
//   core_ready/core_result_valid/core_result  completion pulses and result from the core
//
// Build option: define AES_HOST_TIMEOUT_EN to build the response watchdog. Without it,
// err_timeout is tied low and the wait states wait indefinitely.
module aes_host_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_load,
    output logic         cfg_ready,
    input  logic [255:0] cfg_key,
    input  logic         cfg_keylen,
    output logic         key_valid,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         in_encdec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         err_timeout,
    output logic         core_init,
    output logic         core_next,
    output logic [255:0] core_key,
    output logic         core_keylen,
    output logic [127:0] core_block,
    output logic         core_encdec,
    input  logic         core_ready,
    input  logic         core_result_valid,
    input  logic [127:0] core_result
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_KEY_WAIT = 2'd1;
    localparam logic [1:0] ST_BLK_WAIT = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         key_valid_q, key_valid_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_block_q, out_block_d;
    logic         core_init_q, core_init_d;
    logic         core_next_q, core_next_d;
    logic [255:0] core_key_q, core_key_d;
    logic         core_keylen_q, core_keylen_d;
    logic [127:0] core_block_q, core_block_d;
    logic         core_encdec_q, core_encdec_d;

    logic is_idle, start_key, start_blk, key_done, blk_done, timeout;

    assign is_idle   = (state_q == ST_IDLE);
    // cfg_load wins over a block in the same IDLE cycle, so it masks in_ready.
    assign in_ready  = is_idle & key_valid_q & ~cfg_load & (~out_valid_q | out_ready);
    assign start_key = is_idle & cfg_load;
    assign start_blk = in_valid & in_ready;
    // Core pulses only count in the state that expects them; late or stray pulses are dropped.
    assign key_done  = (state_q == ST_KEY_WAIT) & core_ready;
    assign blk_done  = (state_q == ST_BLK_WAIT) & core_result_valid;

`ifdef AES_HOST_TIMEOUT_EN
    localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       err_timeout_q, err_timeout_d;

    // Firing on the last count gives exactly TIMEOUT_CYCLES cycles in the wait state.
    assign timeout = ~is_idle & ~key_done & ~blk_done & (wd_cnt_q == WdLast);

    always_comb begin
        wd_cnt_d      = wd_cnt_q;
        err_timeout_d = err_timeout_q;
        if (start_key || start_blk) begin
            wd_cnt_d = '0;
        end else if (!is_idle) begin
            wd_cnt_d = wd_cnt_q + 8'd1;
        end
        if (start_key) begin
            err_timeout_d = 1'b0;
        end else if (timeout) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
    assign err_timeout        = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        key_valid_d   = key_valid_q;
        out_valid_d   = out_valid_q;
        out_block_d   = out_block_q;
        core_init_d   = 1'b0;
        core_next_d   = 1'b0;
        core_key_d    = core_key_q;
        core_keylen_d = core_keylen_q;
        core_block_d  = core_block_q;
        core_encdec_d = core_encdec_q;

        // A result landing on a drain cycle overrides the drain.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (blk_done) begin
            out_valid_d = 1'b1;
            out_block_d = core_result;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_key) begin
                    core_key_d    = cfg_key;
                    core_keylen_d = cfg_keylen;
                    key_valid_d   = 1'b0;
                    core_init_d   = 1'b1;
                    state_d       = ST_KEY_WAIT;
                end else if (start_blk) begin
                    core_block_d  = in_block;
                    core_encdec_d = in_encdec;
                    core_next_d   = 1'b1;
                    state_d       = ST_BLK_WAIT;
                end
            end
            ST_KEY_WAIT: begin
                if (key_done) begin
                    key_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (timeout) begin
                    key_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_BLK_WAIT: begin
                if (blk_done || timeout) begin
                    state_d = ST_IDLE;
                end
                if (timeout) begin
                    key_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            key_valid_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_block_q   <= '0;
            core_init_q   <= 1'b0;
            core_next_q   <= 1'b0;
            core_key_q    <= '0;
            core_keylen_q <= 1'b0;
            core_block_q  <= '0;
            core_encdec_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_valid_q   <= key_valid_d;
            out_valid_q   <= out_valid_d;
            out_block_q   <= out_block_d;
            core_init_q   <= core_init_d;
            core_next_q   <= core_next_d;
            core_key_q    <= core_key_d;
            core_keylen_q <= core_keylen_d;
            core_block_q  <= core_block_d;
            core_encdec_q <= core_encdec_d;
        end
    end

    assign cfg_ready   = is_idle;
    assign key_valid   = key_valid_q;
    assign out_valid   = out_valid_q;
    assign out_block   = out_block_q;
    assign core_init   = core_init_q;
    assign core_next   = core_next_q;
    assign core_key    = core_key_q;
    assign core_keylen = core_keylen_q;
    assign core_block  = core_block_q;
    assign core_encdec = core_encdec_q;

endmodule

// File: doc/aes_host_ctrl.md
# aes_host_ctrl

Host-side sequencer that drives the AES core's init/next command interface. It turns a key-load request and a valid/ready stream of 128-bit blocks into correctly ordered core commands, holding operands stable for the whole operation. Each core result is captured into a valid/ready output register. It sits between the bus or DMA front end and the AES core, with an optional watchdog on core responses.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait, in cycles, for core_ready or core_result_valid before the watchdog aborts (1..255).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_load  in  1  key-load request; accepted only when cfg_ready=1.
- cfg_ready  out  1  high in IDLE.
- cfg_key  in  256  key; AES-128 uses bits [255:128].
- cfg_keylen  in  1  0 = AES-128, 1 = AES-256.
- key_valid  out  1  an expanded key is present in the core.
- in_valid / in_ready  in / out  1 / 1  block input handshake.
- in_block  in  128  plaintext or ciphertext.
- in_encdec  in  1  1 = encipher, 0 = decipher.
- out_valid / out_ready  out / in  1 / 1  result output handshake.
- out_block  out  128  captured core result.
- err_timeout  out  1  sticky watchdog flag.
- core_init, core_next  out  1  single-cycle command pulses to the core.
- core_key  out  256  latched key.
- core_keylen  out  1  latched key length.
- core_block  out  128  latched block.
- core_encdec  out  1  latched direction.
- core_ready, core_result_valid  in  1  single-cycle completion pulses from the core.
- core_result  in  128  core output, valid when core_result_valid=1.

## Operation
- States: IDLE, KEY_WAIT, BLK_WAIT.
- **IDLE, cfg_load=1** (priority over in_valid):
  - latch cfg_key/cfg_keylen into core_key/core_keylen;
  - clear key_valid and err_timeout;
  - pulse core_init for one cycle;
  - go to KEY_WAIT.
- **IDLE, block accept:**
  - in_ready = key_valid & ~cfg_load & (~out_valid | out_ready);
  - on in_valid & in_ready: latch in_block into core_block and in_encdec into core_encdec, pulse core_next for one cycle, go to BLK_WAIT.
- **KEY_WAIT:**
  - core_ready=1 sets key_valid and returns to IDLE;
  - core_result_valid is ignored here.
- **BLK_WAIT:**
  - core_result_valid=1 loads core_result into out_block, sets out_valid and returns to IDLE;
  - core_ready is ignored here.
- **Operand stability:** core_key, core_keylen, core_block and core_encdec change only on an accepted command. They are stable for the whole of KEY_WAIT and BLK_WAIT.
- **Output register:**
  - out_valid stays high and out_block stays stable until out_valid & out_ready;
  - if a new result arrives in the same cycle as a drain, the new result wins and out_valid stays 1.
- **Ignored inputs:** cfg_load and in_valid outside IDLE are ignored; cfg_ready=0 and in_ready=0 there.
- **Watchdog:**
  - an 8-bit counter clears on entry to KEY_WAIT or BLK_WAIT and increments each cycle in those states;
  - when it reaches TIMEOUT_CYCLES with no response: set err_timeout, clear key_valid, return to IDLE.
  - A late core pulse arriving in IDLE is ignored.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - cfg_ready=1, key_valid=0, in_ready=0, out_valid=0, err_timeout=0;
  - core_init=0, core_next=0;
  - out_block, core_key, core_block = 0; core_keylen=0, core_encdec=0.
- Commands: core_init/core_next are registered and assert in the cycle after the accepting edge, for exactly one cycle.
- Minimum gap between core_ready or core_result_valid and the next core command is 1 cycle, because the core returns to idle on the same edge.
- Result latency: out_valid rises on the edge after core_result_valid is sampled.
- Throughput: one block per (core latency + 2) cycles when out_ready is held at 1.
- Reset mid-operation aborts immediately. No command pulse is issued after reset deasserts until a new request arrives.

## Configuration
- AES_HOST_TIMEOUT_EN:
  - **defined:** the watchdog and err_timeout are implemented as described above.
  - **undefined:** no counter is built, err_timeout is tied to 0, and KEY_WAIT/BLK_WAIT wait indefinitely.

## Test plan
- **Key load:** cfg_load with key 000102030405060708090a0b0c0d0e0f (in [255:128]) and keylen=0 -> exactly one core_init pulse; key_valid=1 one cycle after core_ready.
- **AES-128 encipher:** block 00112233445566778899aabbccddeeff with in_encdec=1 -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid held while out_ready=0.
- **AES-128 decipher:** the same ciphertext with in_encdec=0 -> out_block 00112233445566778899aabbccddeeff; core_encdec stays 0 throughout BLK_WAIT.
- **Back-to-back with backpressure:** in_valid=1 with key_valid=0 -> in_ready=0 and no core_next; 4 back-to-back blocks with out_ready toggling -> 4 results, in order, none lost or duplicated.
- **Simultaneous requests:** cfg_load and in_valid in the same IDLE cycle -> core_init issued and the block is not accepted.
- **Watchdog (macro defined):** core never responds, TIMEOUT_CYCLES=16 -> err_timeout=1 and key_valid=0 after 16 cycles; rst asserted mid-BLK_WAIT -> all outputs return to reset values asynchronously.
